// File: rtl/logic_cond_pipe.sv
// Multi-lane conditional selector (gate / sample-and-hold) with saturating hit
// counters and a 2-entry output buffer under valid/ready flow control.
module logic_cond_pipe #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CHANNELS     = 4,
  parameter bit          DEFAULT_MODE = 1'b0,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_cond,
  input  logic                      cfg_we,
  input  logic [CHANNELS-1:0]       cfg_mode,
  input  logic                      cnt_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS*CNT_W-1:0] hit_cnt
);

  localparam int unsigned DW = CHANNELS * WIDTH;
  localparam int unsigned CW = CHANNELS * CNT_W;

  logic [CHANNELS-1:0] mode_q;
  logic [DW-1:0]       hold_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_nxt;
  logic [DW-1:0]       head_q;
  logic [DW-1:0]       tail_q;
  logic [1:0]          count_q;
  logic [1:0]          count_nxt;
  logic                out_valid_q;
  logic                in_ready_q;
  logic [DW-1:0]       word_c;
  logic                accept;
  logic                pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  // Lane select: ?: keeps X-merge semantics on an unknown condition bit.
  always_comb begin
    word_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      word_c[i*WIDTH +: WIDTH] = in_cond[i] ? in_data[i*WIDTH +: WIDTH]
                               : (mode_q[i] ? hold_q[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
  end

  // Saturating counters; only a definite 1 counts, clear dominates.
  always_comb begin
    cnt_nxt = cnt_q;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (cnt_clr) begin
        cnt_nxt[i*CNT_W +: CNT_W] = '0;
      end else if (accept && (in_cond[i] == 1'b1) &&
                   (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_nxt[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    count_nxt = count_q;
    if (accept && !pop) begin
      count_nxt = count_q + 2'd1;
    end else if (!accept && pop) begin
      count_nxt = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= {CHANNELS{DEFAULT_MODE}};
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      if (cfg_we) begin
        mode_q <= cfg_mode;
      end
      if (accept) begin
        hold_q <= word_c;
      end
    end
  end

  // Two-register buffer: head drives out_data directly, tail is the second slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (pop && (count_q == 2'd2)) begin
        head_q <= tail_q;
      end
      if (accept) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          head_q <= word_c;
        end else begin
          tail_q <= word_c;
        end
      end
      count_q     <= count_nxt;
      out_valid_q <= (count_nxt != 2'd0);
      in_ready_q  <= (count_nxt != 2'd2);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
  assign hit_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_cond_pipe.sv
// Bench for logic_cond_pipe: directed scenarios plus random traffic against a
// queue-based behavioural model (CNT_W=2, DEFAULT_MODE=1 to reach saturation).
module tb_logic_cond_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned DW = W * CH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CH-1:0] in_cond;
  logic          cfg_we;
  logic [CH-1:0] cfg_mode;
  logic          cnt_clr;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CH*CW-1:0] hit_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mq[$];
  logic [W-1:0]  mhold[CH];
  bit            mmode[CH];
  int            mcnt[CH];

  logic_cond_pipe #(.WIDTH(W), .CHANNELS(CH), .DEFAULT_MODE(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cond(in_cond), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .cnt_clr(cnt_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [CH*CW-1:0] model_cnt();
    logic [CH*CW-1:0] r;
    for (int i = 0; i < int'(CH); i++) r[i*CW +: CW] = CW'(mcnt[i]);
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < int'(CH); i++) begin
      mhold[i] = '0;
      mmode[i] = 1'b1;
      mcnt[i]  = 0;
    end
  endtask

  // Drives one cycle from a negedge, advances the model at the posedge, returns at the next negedge.
  task automatic drive_cycle(input bit iv, input logic [DW-1:0] d, input logic [CH-1:0] c,
                             input bit we, input logic [CH-1:0] m, input bit clr, input bit ordy);
    bit acc, pp;
    logic [DW-1:0] w;
    in_valid = iv; in_data = d; in_cond = c; cfg_we = we; cfg_mode = m;
    cnt_clr = clr; out_ready = ordy;
    acc = iv && (mq.size() < 2);
    pp  = (mq.size() > 0) && ordy;
    for (int i = 0; i < int'(CH); i++)
      w[i*W +: W] = c[i] ? d[i*W +: W] : (mmode[i] ? mhold[i] : {W{1'b0}});
    @(posedge clk);
    if (acc) begin
      for (int i = 0; i < int'(CH); i++) begin
        mhold[i] = w[i*W +: W];
        if ((c[i] == 1'b1) && (mcnt[i] < (1 << CW) - 1)) mcnt[i]++;
      end
    end
    if (clr) for (int i = 0; i < int'(CH); i++) mcnt[i] = 0;
    if (we) for (int i = 0; i < int'(CH); i++) mmode[i] = m[i];
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back(w);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = '1; in_cond = '1; cfg_we = 1'b0;
    cfg_mode = '0; cnt_clr = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    if (hit_cnt !== '0) begin failures++; $display("FAIL reset_hit_cnt got=%h exp=0", hit_cnt); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    // Reset mode is hold in every lane: cond=0 must return the previous word.
    drive_cycle(1'b1, 32'h7777_7777, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h0000_0000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checks += 2;
    if (out_data !== 32'h7777_7777) begin failures++; $display("FAIL reset_default_mode got=%h exp=77777777", out_data); end
    if (hit_cnt !== 8'h55) begin failures++; $display("FAIL reset_mode_cnt got=%h exp=55", hit_cnt); end
  endtask

  task automatic test_gate();
    drive_cycle(1'b0, '0, '0, 1'b1, 4'h0, 1'b1, 1'b1);
    drive_cycle(1'b1, 32'hAA55_0FF0, 4'b0101, 1'b0, 4'h0, 1'b0, 1'b1);
    checks += 3;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL gate_valid got=%b exp=1", out_valid); end
    if (out_data !== 32'h0055_00F0) begin failures++; $display("FAIL gate_data got=%h exp=005500f0", out_data); end
    if (hit_cnt !== 8'h11) begin failures++; $display("FAIL gate_cnt got=%h exp=11", hit_cnt); end
  endtask

  task automatic test_hold();
    drive_cycle(1'b0, '0, '0, 1'b1, 4'hF, 1'b1, 1'b1);
    drive_cycle(1'b1, 32'h1212_1212, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h3434_3434, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++;
    if (out_data !== 32'h1212_1212) begin failures++; $display("FAIL hold_all got=%h exp=12121212", out_data); end
    drive_cycle(1'b1, 32'h3434_3434, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++;
    if (out_data !== 32'h1212_1234) begin failures++; $display("FAIL hold_lane0 got=%h exp=12121234", out_data); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] got[$];
    bit sent, drained;
    drive_cycle(1'b0, '0, '0, 1'b0, 4'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h0101_0101, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h0202_0202, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    checks += 2;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    if (out_data !== 32'h0101_0101) begin failures++; $display("FAIL bp_head got=%h exp=01010101", out_data); end
    drive_cycle(1'b1, 32'h0303_0303, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    checks += 3;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_held_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_held_valid got=%b exp=1", out_valid); end
    if (out_data !== 32'h0101_0101) begin failures++; $display("FAIL bp_stable got=%h exp=01010101", out_data); end
    sent = 1'b0;
    drained = 1'b0;
    for (int k = 0; k < 8 && !drained; k++) begin
      if (out_valid !== 1'b1) begin
        drained = 1'b1;
      end else begin
        got.push_back(out_data);
        if (!sent && mq.size() < 2) begin
          drive_cycle(1'b1, 32'h0303_0303, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1);
          sent = 1'b1;
        end else begin
          drive_cycle(!sent, 32'h0303_0303, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1);
        end
      end
    end
    checks += 2;
    if (!drained || got.size() != 3) begin
      failures++; $display("FAIL bp_drain_count got=%0d exp=3 drained=%0b", got.size(), drained);
    end
    if (got.size() != 3 || got[0] !== 32'h0101_0101 || got[1] !== 32'h0202_0202 || got[2] !== 32'h0303_0303) begin
      failures++; $display("FAIL bp_order got_n=%0d exp=01010101,02020202,03030303", got.size());
    end
  endtask

  task automatic test_xz();
    logic [CH-1:0] c;
    drive_cycle(1'b0, '0, '0, 1'b1, 4'h0, 1'b0, 1'b1);
    for (int r = 0; r < 2; r++) begin
      c = 4'b0000;
      c[0] = (r == 0) ? 1'bx : 1'bz;
      drive_cycle(1'b1, 32'h0000_00A0, c, 1'b0, 4'h0, 1'b0, 1'b1);
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL xz_valid r=%0d got=%b exp=1", r, out_valid); end
      if (out_data[W-1:0] !== mq[0][W-1:0]) begin
        failures++; $display("FAIL xz_lane0 r=%0d got=%b exp=%b", r, out_data[W-1:0], mq[0][W-1:0]);
      end
      if (hit_cnt !== model_cnt()) begin failures++; $display("FAIL xz_cnt r=%0d got=%h exp=%h", r, hit_cnt, model_cnt()); end
    end
  endtask

  task automatic test_edges();
    drive_cycle(1'b0, '0, '0, 1'b0, 4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, $urandom, 4'b0001, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++;
    if (hit_cnt[CW-1:0] !== 2'd3) begin failures++; $display("FAIL edge_saturate got=%0d exp=3", hit_cnt[CW-1:0]); end
    drive_cycle(1'b1, $urandom, 4'b0001, 1'b0, 4'h0, 1'b1, 1'b1);
    checks++;
    if (hit_cnt[CW-1:0] !== 2'd0) begin failures++; $display("FAIL edge_clr_wins got=%0d exp=0", hit_cnt[CW-1:0]); end
    // Gate -> hold written on the same edge as an accept: the accept still gates.
    drive_cycle(1'b1, 32'h5A5A_5A5A, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1);
    checks++;
    if (out_data !== 32'h0000_0000) begin failures++; $display("FAIL edge_old_mode got=%h exp=00000000", out_data); end
    drive_cycle(1'b1, 32'h6666_6666, 4'hF, 1'b0, 4'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h0000_0000, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checks++;
    if (out_data !== 32'h6666_6666) begin failures++; $display("FAIL edge_new_mode got=%h exp=66666666", out_data); end
    drive_cycle(1'b1, 32'h1111_1111, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h2222_2222, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL edge_prefull got=%b%b exp=10", out_valid, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL edge_rst_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin failures++; $display("FAIL edge_rst_data got=%h exp=0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive_cycle(($urandom % 4) != 0, $urandom, 4'($urandom), ($urandom % 8) == 0,
                  4'($urandom), ($urandom % 16) == 0, ($urandom % 3) != 0);
      checks += 3;
      if (out_valid !== (mq.size() > 0)) begin
        failures++; $display("FAIL rnd_valid k=%0d got=%b exp=%b", k, out_valid, mq.size() > 0);
      end
      if (in_ready !== (mq.size() < 2)) begin
        failures++; $display("FAIL rnd_ready k=%0d got=%b exp=%b", k, in_ready, mq.size() < 2);
      end
      if (hit_cnt !== model_cnt()) begin
        failures++; $display("FAIL rnd_cnt k=%0d got=%h exp=%h", k, hit_cnt, model_cnt());
      end
      if (mq.size() > 0) begin
        checks++;
        if (out_data !== mq[0]) begin
          failures++; $display("FAIL rnd_data k=%0d got=%h exp=%h", k, out_data, mq[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_gate();
    test_hold();
    test_backpressure();
    test_xz();
    test_edges();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
